// File: rtl/multi_lane_block_solver_pkg.sv
// Shared constants, state encodings and helpers for the multi-lane double-SHA256 nonce searcher.
package multi_lane_block_solver_pkg;

    localparam logic [255:0] SHA256_IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    localparam logic [7:0]  PAD_BYTE = 8'h80;
    localparam logic [15:0] LEN_BLK1 = 16'h0280;  // 80-byte header
    localparam logic [15:0] LEN_BLK2 = 16'h0100;  // 32-byte first digest

    // Start-to-done latency of the iterative compression core.
    localparam int SHA_LAT = 65;

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} top_state_e;
    typedef enum logic [2:0] {L_IDLE, L_PRE1, L_HASH1, L_PRE2, L_HASH2} lane_state_e;

    // Byte i of the result takes byte 31-i of the input (byte 0 = bits [7:0]).
    function automatic logic [255:0] byte_reverse256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) begin
            r[8*i +: 8] = x[8*(31-i) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_lane_block_solver_lane.sv
// One search lane: walks nonces base, base+stride, ... through a double SHA-256 and
// flags any byte-reversed result strictly below target.
module multi_lane_block_solver_lane
    import multi_lane_block_solver_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [32:0]  base_nonce,
    input  logic [4:0]   stride,
    input  logic [31:0]  nonce_end,
    input  logic         kill,
    input  logic [255:0] midstate,
    input  logic [95:0]  leftovers,
    input  logic [255:0] target,
    output logic         hit,
    output logic [31:0]  hit_nonce,
    output logic [255:0] hit_hash,
    output logic         tried,
    output logic         idle
);

    lane_state_e  state_q, state_d;
    logic [31:0]  nonce_q, nonce_d;
    logic         first_q, first_d;
    logic [255:0] hash1_q, hash1_d;

    logic         sha_start, sha_done, result_ok;
    logic [255:0] sha_init, sha_digest, rev;
    logic [511:0] sha_block;
    logic [31:0]  nonce_le;
    logic [32:0]  next_nonce;

    // The header carries the nonce little-endian.
    assign nonce_le   = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    assign sha_start  = (state_q == L_PRE1) || (state_q == L_PRE2);
    assign sha_init   = (state_q == L_PRE2) ? SHA256_IV : midstate;
    assign sha_block  = (state_q == L_PRE2) ? {hash1_q, PAD_BYTE, 232'b0, LEN_BLK2}
                                            : {leftovers, nonce_le, PAD_BYTE, 360'b0, LEN_BLK1};
    assign rev        = byte_reverse256(sha_digest);
    assign next_nonce = {1'b0, nonce_q} + {28'b0, stride};
    assign result_ok  = sha_done && !first_q;

    multi_lane_block_solver_sha u_sha (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (sha_start),
        .init_state (sha_init),
        .block      (sha_block),
        .done       (sha_done),
        .digest     (sha_digest)
    );

    always_comb begin
        state_d = state_q;
        nonce_d = nonce_q;
        hash1_d = hash1_q;
        hit     = 1'b0;
        tried   = 1'b0;
        case (state_q)
            L_IDLE: begin
                if (go && (base_nonce <= {1'b0, nonce_end})) begin
                    nonce_d = base_nonce[31:0];
                    state_d = L_PRE1;
                end
            end
            L_PRE1: state_d = L_HASH1;
            L_HASH1: begin
                if (result_ok) begin
                    hash1_d = sha_digest;
                    state_d = L_PRE2;
                end
            end
            L_PRE2: state_d = L_HASH2;
            L_HASH2: begin
                if (result_ok) begin
                    tried = 1'b1;
                    hit   = (rev < target);
                    // 33-bit compare keeps the walk from wrapping past 0xFFFFFFFF.
                    if (next_nonce > {1'b0, nonce_end}) begin
                        state_d = L_IDLE;
                    end else begin
                        nonce_d = next_nonce[31:0];
                        state_d = L_PRE1;
                    end
                end
            end
            default: state_d = L_IDLE;
        endcase
        if (kill) begin
            state_d = L_IDLE;
        end
        // The core's done from the previous hash is still visible right after a start.
        first_d = sha_start;
    end

    assign hit_nonce = nonce_q;
    assign hit_hash  = rev;
    assign idle      = (state_q == L_IDLE);

    always_ff @(posedge clk) begin
        nonce_q <= nonce_d;
        hash1_q <= hash1_d;
        if (!rst_n) begin
            state_q <= L_IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

endmodule

// File: rtl/multi_lane_block_solver_sha.sv
// Iterative SHA-256 compression core: one round per cycle; done stays high until the
// cycle after the next start, with the digest held stable meanwhile.
module multi_lane_block_solver_sha
    import multi_lane_block_solver_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] init_state,
    input  logic [511:0] block,
    output logic         done,
    output logic [255:0] digest
);

    logic [255:0] st_q, st_d;
    logic [255:0] init_q, init_d;
    logic [511:0] w_q, w_d;
    logic         run_q, run_d;
    logic         done_q, done_d;
    logic [5:0]   round_q, round_d;

    logic [31:0]  a, b, c, d, e, f, g, h;
    logic [31:0]  w0, w1, w9, w14;
    logic [31:0]  t1, t2;
    logic [255:0] round_st;
    logic [511:0] w_next;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    always_comb begin
        {a, b, c, d, e, f, g, h} = st_q;
        w0  = w_q[511:480];
        w1  = w_q[479:448];
        w9  = w_q[223:192];
        w14 = w_q[63:32];
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g))
             + SHA_K[round_q] + w0;
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        round_st = {t1 + t2, a, b, c, d + t1, e, f, g};
        // Sliding 16-word window: the head word is consumed, W[t+16] is appended.
        w_next = {w_q[479:0],
                  (rotr(w14, 17) ^ rotr(w14, 19) ^ (w14 >> 10)) + w9
                  + (rotr(w1, 7) ^ rotr(w1, 18) ^ (w1 >> 3)) + w0};

        st_d    = st_q;
        init_d  = init_q;
        w_d     = w_q;
        run_d   = run_q;
        done_d  = done_q;
        round_d = round_q;
        if (start) begin
            st_d    = init_state;
            init_d  = init_state;
            w_d     = block;
            run_d   = 1'b1;
            done_d  = 1'b0;
            round_d = 6'd0;
        end else if (run_q) begin
            st_d    = round_st;
            w_d     = w_next;
            round_d = round_q + 6'd1;
            if (round_q == 6'(SHA_LAT - 2)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_comb begin
        digest = '0;
        for (int i = 0; i < 8; i++) begin
            digest[32*i +: 32] = init_q[32*i +: 32] + st_q[32*i +: 32];
        end
    end

    assign done = done_q;

    always_ff @(posedge clk) begin
        st_q   <= st_d;
        init_q <= init_d;
        w_q    <= w_d;
        if (!rst_n) begin
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            round_q <= 6'd0;
        end else begin
            run_q   <= run_d;
            done_q  <= done_d;
            round_q <= round_d;
        end
    end

endmodule

// File: rtl/multi_lane_block_solver.sv
// Parallel double-SHA256 nonce searcher: NUM_LANES interleaved lanes over [nonce_start, nonce_end],
// with start/abort control, hit priority, tried-count and winning-hash readout.
module multi_lane_block_solver
    import multi_lane_block_solver_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter bit STOP_ON_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [255:0] midstate,
    input  logic [95:0]  header_leftovers,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic [31:0]  nonces_tried
);

    top_state_e   state_q, state_d;
    logic         busy_q, busy_d;
    logic         found_q, found_d;
    logic         exhausted_q, exhausted_d;
    logic [31:0]  found_nonce_q, found_nonce_d;
    logic [255:0] found_hash_q, found_hash_d;
    logic [31:0]  tried_q, tried_d;

    logic [255:0] mid_q, mid_d;
    logic [95:0]  left_q, left_d;
    logic [255:0] target_q, target_d;
    logic [31:0]  end_q, end_d;

    logic                 accept, kill, any_hit, all_idle;
    logic [4:0]           n_done;
    logic [31:0]          sel_nonce;
    logic [255:0]         sel_hash;
    logic [NUM_LANES-1:0] lane_hit, lane_tried, lane_idle;
    logic [31:0]          lane_nonce [NUM_LANES];
    logic [255:0]         lane_hash  [NUM_LANES];

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [4:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {28'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Lanes launch in the accept cycle itself, so they see the raw inputs then
    // and the latched copy for the rest of the run.
    assign accept   = start && (state_q != T_RUN);
    assign mid_d    = accept ? midstate         : mid_q;
    assign left_d   = accept ? header_leftovers : left_q;
    assign target_d = accept ? target           : target_q;
    assign end_d    = accept ? nonce_end        : end_q;
    assign kill     = (state_q == T_RUN) && (abort || (STOP_ON_FIRST && any_hit));

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        multi_lane_block_solver_lane u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .go         (accept),
            .base_nonce ({1'b0, nonce_start} + 33'(k)),
            .stride     (5'(NUM_LANES)),
            .nonce_end  (end_d),
            .kill       (kill),
            .midstate   (mid_d),
            .leftovers  (left_d),
            .target     (target_d),
            .hit        (lane_hit[k]),
            .hit_nonce  (lane_nonce[k]),
            .hit_hash   (lane_hash[k]),
            .tried      (lane_tried[k]),
            .idle       (lane_idle[k])
        );
    end

    // Scanning downward lets the lowest-index hitting lane win.
    always_comb begin
        any_hit   = 1'b0;
        all_idle  = 1'b1;
        n_done    = 5'd0;
        sel_nonce = '0;
        sel_hash  = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (lane_hit[k]) begin
                any_hit   = 1'b1;
                sel_nonce = lane_nonce[k];
                sel_hash  = lane_hash[k];
            end
            all_idle = all_idle & lane_idle[k];
            n_done   = n_done + {4'b0, lane_tried[k]};
        end
    end

    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        found_nonce_d = found_nonce_q;
        found_hash_d  = found_hash_q;
        tried_d       = tried_q;
        case (state_q)
            T_RUN: begin
                if (abort) begin
                    state_d     = T_DONE;
                    busy_d      = 1'b0;
                    exhausted_d = 1'b0;
                end else begin
                    tried_d = sat_add(tried_q, n_done);
                    if (any_hit) begin
                        found_d       = 1'b1;
                        found_nonce_d = sel_nonce;
                        found_hash_d  = sel_hash;
                    end
                    if (STOP_ON_FIRST && any_hit) begin
                        state_d     = T_DONE;
                        busy_d      = 1'b0;
                        exhausted_d = 1'b0;
                    end else if (all_idle) begin
                        state_d     = T_DONE;
                        busy_d      = 1'b0;
                        exhausted_d = !STOP_ON_FIRST || !found_q;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = T_RUN;
                    busy_d      = 1'b1;
                    found_d     = 1'b0;
                    exhausted_d = 1'b0;
                    tried_d     = '0;
                end
            end
        endcase
    end

    assign busy         = busy_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign found_nonce  = found_nonce_q;
    assign found_hash   = found_hash_q;
    assign nonces_tried = tried_q;

    always_ff @(posedge clk) begin
        mid_q    <= mid_d;
        left_q   <= left_d;
        target_q <= target_d;
        end_q    <= end_d;
        if (!rst_n) begin
            state_q       <= T_IDLE;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            found_nonce_q <= '0;
            found_hash_q  <= '0;
            tried_q       <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            found_nonce_q <= found_nonce_d;
            found_hash_q  <= found_hash_d;
            tried_q       <= tried_d;
        end
    end

endmodule

// File: tb/tb_multi_lane_block_solver.sv
// Directed bench for multi_lane_block_solver built around the Bitcoin genesis header.
module tb_multi_lane_block_solver;

    localparam int TB_SHA_LAT = 65;

    localparam logic [255:0] IV_TB =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Genesis header: version, null prev-hash, first 28 merkle bytes | last 12 bytes.
    localparam logic [511:0] GEN_BLK1 = {32'h01000000, 256'h0,
        224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa};
    localparam logic [95:0]  GEN_LEFT = 96'h4b1e5e4a_29ab5f49_ffff001d;
    localparam logic [255:0] GEN_HASH =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [255:0] GEN_TGT  = {64'h0000_0000_0020_0000, 192'h0};
    localparam logic [255:0] T_ALL    = {256{1'b1}};
    localparam logic [255:0] T_ZERO   = 256'h0;

    logic         clk = 1'b0;
    logic         rst_n, start, abort;
    logic [255:0] midstate, target;
    logic [95:0]  header_leftovers;
    logic [31:0]  nonce_start, nonce_end;
    logic         busy, found, exhausted;
    logic [31:0]  found_nonce, nonces_tried;
    logic [255:0] found_hash;

    int total = 0;
    int bad   = 0;
    int cyc;

    always #5 clk = ~clk;

    multi_lane_block_solver dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .abort            (abort),
        .midstate         (midstate),
        .header_leftovers (header_leftovers),
        .target           (target),
        .nonce_start      (nonce_start),
        .nonce_end        (nonce_end),
        .busy             (busy),
        .found            (found),
        .exhausted        (exhausted),
        .found_nonce      (found_nonce),
        .found_hash       (found_hash),
        .nonces_tried     (nonces_tried)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        end
        for (int j = 0; j < 8; j++) v[j] = hin[255-32*j -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[i] + w[i];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) hout[255-32*j -: 32] = hin[255-32*j -: 32] + v[j];
        return hout;
    endfunction

    // Displayed (byte-reversed) double hash of the genesis header with a given nonce.
    function automatic logic [255:0] model_hash(input logic [31:0] nonce);
        logic [255:0] h1, h2, r;
        h1 = compress(compress(IV_TB, GEN_BLK1),
                      {GEN_LEFT, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24],
                       8'h80, 360'b0, 16'h0280});
        h2 = compress(IV_TB, {h1, 8'h80, 232'b0, 16'h0100});
        for (int i = 0; i < 32; i++) r[8*i +: 8] = h2[255-8*i -: 8];
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
        @(posedge clk);
        #1;
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which busy is first seen low.
    task automatic wait_idle(input int budget, output int n);
        n = 1;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_wait", 256'(busy), 256'(0));
    endtask

    initial begin
        rst_n            = 1'b0;
        start            = 1'b0;
        abort            = 1'b0;
        nonce_start      = '0;
        nonce_end        = '0;
        target           = '0;
        header_leftovers = GEN_LEFT;
        midstate         = compress(IV_TB, GEN_BLK1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  256'(busy),         256'(0));
        check("rst_found", 256'(found),        256'(0));
        check("rst_exh",   256'(exhausted),    256'(0));
        check("rst_nonce", 256'(found_nonce),  256'(0));
        check("rst_tried", 256'(nonces_tried), 256'(0));
        check("rst_hash",  found_hash,         256'(0));
        rst_n = 1'b1;

        // Every hash hits: all four lanes hit together, lane 0 wins.
        do_start(32'h10, 32'hFF, T_ALL);
        wait_idle(400, cyc);
        check("all_lat",   256'(cyc),          256'(2 * TB_SHA_LAT + 3));
        check("all_found", 256'(found),        256'(1));
        check("all_nonce", 256'(found_nonce),  256'(32'h10));
        check("all_hash",  found_hash,         model_hash(32'h10));
        check("all_tried", 256'(nonces_tried), 256'(4));
        check("all_exh",   256'(exhausted),    256'(0));

        // Nothing can hit: whole range of 8 runs out.
        do_start(32'h0, 32'h7, T_ZERO);
        wait_idle(600, cyc);
        check("miss_exh",   256'(exhausted),    256'(1));
        check("miss_found", 256'(found),        256'(0));
        check("miss_tried", 256'(nonces_tried), 256'(8));

        // Top of the nonce space: only two lanes run and nobody wraps to 0.
        do_start(32'hFFFF_FFFE, 32'hFFFF_FFFF, T_ZERO);
        wait_idle(600, cyc);
        check("top_tried", 256'(nonces_tried), 256'(2));
        check("top_exh",   256'(exhausted),    256'(1));
        check("top_found", 256'(found),        256'(0));
        check("top_lat",   256'(cyc),          256'(2 * TB_SHA_LAT + 4));

        // Empty range.
        do_start(32'd5, 32'd4, T_ALL);
        wait_idle(50, cyc);
        check("empty_lat",   256'(cyc),          256'(2));
        check("empty_exh",   256'(exhausted),    256'(1));
        check("empty_tried", 256'(nonces_tried), 256'(0));

        // Genesis block: winner 0x7C2BAC1D on lane 1 in the eighth round.
        do_start(32'h7C2B_AC00, 32'h7C2B_ACFF, GEN_TGT);
        wait_idle(2000, cyc);
        check("gen_found", 256'(found),        256'(1));
        check("gen_nonce", 256'(found_nonce),  256'(32'h7C2B_AC1D));
        check("gen_hash",  found_hash,         GEN_HASH);
        check("gen_model", found_hash,         model_hash(32'h7C2B_AC1D));
        check("gen_tried", 256'(nonces_tried), 256'(32));
        check("gen_exh",   256'(exhausted),    256'(0));

        // Abort a long run 20 cycles in.
        do_start(32'h0, 32'hFFFF, T_ZERO);
        repeat (19) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy",  256'(busy),      256'(0));
        check("abort_found", 256'(found),     256'(0));
        check("abort_exh",   256'(exhausted), 256'(0));

        // Clean restart; a start pulse mid-run with different work is ignored.
        do_start(32'h20, 32'h2F, T_ALL);
        repeat (10) @(posedge clk);
        #1;
        nonce_start = 32'h0;
        nonce_end   = 32'h0;
        target      = T_ZERO;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ign_busy", 256'(busy), 256'(1));
        wait_idle(400, cyc);
        check("ign_found", 256'(found),        256'(1));
        check("ign_nonce", 256'(found_nonce),  256'(32'h20));
        check("ign_hash",  found_hash,         model_hash(32'h20));
        check("ign_tried", 256'(nonces_tried), 256'(4));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
